// File: rtl/te_block_reader_pkg.sv
// Shared widths, itype encodings and the buffered block record for the trace-block reader.
package te_block_reader_pkg;
  localparam int XLEN        = 32;
  localparam int IRETIRE_LEN = 16;
  localparam int ITYPE_LEN   = 3;
  localparam int CAUSE_LEN   = 6;
  localparam int PRIV_LEN    = 2;

  localparam logic [ITYPE_LEN-1:0] ITYPE_NONE = 3'd0;
  localparam logic [ITYPE_LEN-1:0] ITYPE_EXC  = 3'd1;
  localparam logic [ITYPE_LEN-1:0] ITYPE_INT  = 3'd2;
  localparam logic [ITYPE_LEN-1:0] ITYPE_ERET = 3'd3;
  localparam logic [ITYPE_LEN-1:0] ITYPE_NTBR = 3'd4;
  localparam logic [ITYPE_LEN-1:0] ITYPE_TBR  = 3'd5;

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
    logic [XLEN-1:0]        iaddr;
  } blk_entry_s;

  // Trap-only blocks (iretire == 0) have no retired instruction, so both addresses collapse to iaddr.
  function automatic logic [XLEN-1:0] blk_next_addr(input logic [XLEN-1:0] iaddr,
                                                    input logic [IRETIRE_LEN-1:0] iretire);
    return iaddr + (XLEN'(iretire) << 1);
  endfunction
endpackage

// File: rtl/te_block_reader_if.sv
// Multi-lane block ingest plus single-lane replay bus of the trace-block reader.
interface te_block_reader_if #(
  parameter int N          = 1,
  parameter int FIFO_DEPTH = 16
);
  import te_block_reader_pkg::*;
  localparam int UW = $clog2(FIFO_DEPTH) + 1;

  logic [N-1:0]                  valid_i;
  logic [N-1:0][IRETIRE_LEN-1:0] iretire_i;
  logic [N-1:0]                  ilastsize_i;
  logic [N-1:0][ITYPE_LEN-1:0]   itype_i;
  logic [N-1:0][CAUSE_LEN-1:0]   cause_i;
  logic [N-1:0][XLEN-1:0]        tval_i;
  logic [N-1:0][PRIV_LEN-1:0]    priv_i;
  logic [N-1:0][XLEN-1:0]        iaddr_i;

  logic                   valid_o;
  logic                   ready_i;
  logic [IRETIRE_LEN-1:0] iretire_o;
  logic                   ilastsize_o;
  logic [ITYPE_LEN-1:0]   itype_o;
  logic [CAUSE_LEN-1:0]   cause_o;
  logic [XLEN-1:0]        tval_o;
  logic [PRIV_LEN-1:0]    priv_o;
  logic [XLEN-1:0]        iaddr_o;
  logic [XLEN-1:0]        last_addr_o;
  logic [XLEN-1:0]        next_addr_o;
  logic                   seq_err_o;
  logic                   overflow_o;
  logic [15:0]            drop_cnt_o;
  logic [31:0]            retired_hw_o;
  logic [UW-1:0]          usage_o;

  modport master (
    output valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i, ready_i,
    input  valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
           last_addr_o, next_addr_o, seq_err_o, overflow_o, drop_cnt_o, retired_hw_o, usage_o
  );

  modport slave (
    input  valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i, ready_i,
    output valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
           last_addr_o, next_addr_o, seq_err_o, overflow_o, drop_cnt_o, retired_hw_o, usage_o
  );
endinterface

// File: rtl/te_block_reader_lane_compactor.sv
// Packs valid lanes to the low slots in lane order via a running prefix count; k = valid lanes.
module te_lane_compactor
  import te_block_reader_pkg::*;
#(
  parameter int N  = 1,
  parameter int KW = $clog2(N + 1)
) (
  input  logic       [N-1:0] valid,
  input  blk_entry_s [N-1:0] ent_in,
  output blk_entry_s [N-1:0] ent_out,
  output logic [KW-1:0]      k
);
  always_comb begin
    int pos;
    ent_out = '0;
    pos     = 0;
    for (int i = 0; i < N; i++) begin
      if (valid[i]) begin
        for (int j = 0; j < N; j++)
          if (j == pos) ent_out[j] = ent_in[i];
        pos = pos + 1;
      end
    end
    k = KW'(pos);
  end
endmodule

// File: rtl/te_block_reader.sv
// In-order block FIFO: all-or-nothing multi-lane ingest, single-lane replay with address rebuild
// and not-taken-branch continuity check.
module te_block_reader
  import te_block_reader_pkg::*;
#(
  parameter int N          = 1,
  parameter int FIFO_DEPTH = 16
) (
  input logic            clk_i,
  input logic            rst_ni,
  te_block_reader_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int UW = AW + 1;
  localparam int KW = $clog2(N + 1);

  blk_entry_s [N-1:0] lane_ent, comp;
  logic [KW-1:0]      k;
  blk_entry_s         mem [FIFO_DEPTH];
  blk_entry_s         head;

  logic [AW-1:0]   wptr, rptr;
  logic [UW-1:0]   usage, free;
  logic            accept, pop;
  logic [16:0]     drop_sum;
  logic [XLEN-1:0] nxt, prev_next;
  logic [ITYPE_LEN-1:0] prev_itype;
  logic            prev_v, overflow;
  logic [15:0]     drop_cnt;
  logic [31:0]     retired_hw;

  always_comb begin
    lane_ent = '0;
    for (int i = 0; i < N; i++) begin
      lane_ent[i].iretire   = bus.iretire_i[i];
      lane_ent[i].ilastsize = bus.ilastsize_i[i];
      lane_ent[i].itype     = bus.itype_i[i];
      lane_ent[i].cause     = bus.cause_i[i];
      lane_ent[i].tval      = bus.tval_i[i];
      lane_ent[i].priv      = bus.priv_i[i];
      lane_ent[i].iaddr     = bus.iaddr_i[i];
    end
  end

  te_lane_compactor #(.N(N), .KW(KW)) u_compact (
    .valid   (bus.valid_i),
    .ent_in  (lane_ent),
    .ent_out (comp),
    .k       (k)
  );

  // Room is judged on registered usage only; a same-cycle pop never frees space for this push.
  assign free     = UW'(FIFO_DEPTH) - usage;
  assign accept   = UW'(k) <= free;
  assign pop      = bus.valid_o && bus.ready_i;
  assign drop_sum = {1'b0, drop_cnt} + 17'(k);

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < N; j++)
      if (accept && j < int'(k)) mem[wptr + AW'(j)] <= comp[j];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr       <= '0;
      rptr       <= '0;
      usage      <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      retired_hw <= '0;
      prev_next  <= '0;
      prev_itype <= '0;
      prev_v     <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + AW'(k);
      else begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
      usage <= usage + (accept ? UW'(k) : UW'(0)) - UW'(pop);
      if (pop) begin
        rptr       <= rptr + AW'(1);
        retired_hw <= retired_hw + 32'(head.iretire);
        prev_next  <= bus.next_addr_o;
        prev_itype <= head.itype;
        prev_v     <= 1'b1;
      end
    end
  end

  assign bus.valid_o = usage != '0;
  assign head        = bus.valid_o ? mem[rptr] : '0;
  assign nxt         = blk_next_addr(head.iaddr, head.iretire);

  always_comb begin
    bus.next_addr_o = nxt;
    bus.last_addr_o = nxt - (head.ilastsize ? XLEN'(4) : XLEN'(2));
    if (head.iretire == '0) begin
      bus.next_addr_o = head.iaddr;
      bus.last_addr_o = head.iaddr;
    end
  end

  // Only a not-taken branch promises the next block starts where this one ended.
  assign bus.seq_err_o = bus.valid_o && prev_v && prev_itype == ITYPE_NTBR
                         && head.iaddr != prev_next;

  assign bus.iretire_o    = head.iretire;
  assign bus.ilastsize_o  = head.ilastsize;
  assign bus.itype_o      = head.itype;
  assign bus.cause_o      = head.cause;
  assign bus.tval_o       = head.tval;
  assign bus.priv_o       = head.priv;
  assign bus.iaddr_o      = head.iaddr;
  assign bus.overflow_o   = overflow;
  assign bus.drop_cnt_o   = drop_cnt;
  assign bus.retired_hw_o = retired_hw;
  assign bus.usage_o      = usage;
endmodule

// File: tb/tb_te_block_reader.sv
// Directed bench: N=2, FIFO_DEPTH=8; hand-computed expectations checked with immediate assertions.
module tb_te_block_reader;
  logic clk, rst_n;
  int total = 0;
  int bad   = 0;

  te_block_reader_if #(.N(2), .FIFO_DEPTH(8)) bif ();

  te_block_reader #(.N(2), .FIFO_DEPTH(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    bif.valid_i     = '0;
    bif.iretire_i   = '0;
    bif.ilastsize_i = '0;
    bif.itype_i     = '0;
    bif.cause_i     = '0;
    bif.tval_i      = '0;
    bif.priv_i      = '0;
    bif.iaddr_i     = '0;
  endtask

  task automatic lane(input int l, input logic [31:0] a, input logic [15:0] r,
                      input logic ls, input logic [2:0] t);
    bif.valid_i[l]     = 1'b1;
    bif.iaddr_i[l]     = a;
    bif.iretire_i[l]   = r;
    bif.ilastsize_i[l] = ls;
    bif.itype_i[l]     = t;
    bif.cause_i[l]     = 6'(t) + 6'd3;
    bif.tval_i[l]      = ~a;
    bif.priv_i[l]      = 2'(l + 1);
  endtask

  task automatic push;
    tick;
    clr;
  endtask

  task automatic pop1;
    bif.ready_i = 1'b1;
    tick;
    bif.ready_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bif.ready_i = 1'b0;
    clr;
    #2;
    chk("rst_valid", 64'(bif.valid_o), 0);
    chk("rst_usage", 64'(bif.usage_o), 0);
    chk("rst_ovf", 64'(bif.overflow_o), 0);
    chk("rst_drop", 64'(bif.drop_cnt_o), 0);
    chk("rst_ret", 64'(bif.retired_hw_o), 0);
    chk("rst_next", 64'(bif.next_addr_o), 0);
    chk("rst_seq", 64'(bif.seq_err_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // single block, address rebuild
    lane(0, 32'h1000, 16'd3, 1'b1, 3'd0);
    chk("no_comb_path", 64'(bif.valid_o), 0);
    push;
    chk("p1_valid", 64'(bif.valid_o), 1);
    chk("p1_next", 64'(bif.next_addr_o), 64'h1006);
    chk("p1_last", 64'(bif.last_addr_o), 64'h1002);
    chk("p1_tval", 64'(bif.tval_o), 64'hFFFF_EFFF);
    chk("p1_cause", 64'(bif.cause_o), 3);
    chk("p1_priv", 64'(bif.priv_o), 1);
    chk("p1_usage", 64'(bif.usage_o), 1);
    pop1;
    chk("p1_ret", 64'(bif.retired_hw_o), 3);
    chk("p1_empty", 64'(bif.valid_o), 0);

    // two lanes at once, held with ready low
    lane(0, 32'h3000, 16'd2, 1'b0, 3'd5);
    lane(1, 32'h4000, 16'd1, 1'b0, 3'd0);
    push;
    for (int c = 0; c < 3; c++) begin
      chk("hold_usage", 64'(bif.usage_o), 2);
      chk("hold_head", 64'(bif.iaddr_o), 64'h3000);
      tick;
    end
    bif.ready_i = 1'b1;
    tick;
    chk("b_head", 64'(bif.iaddr_o), 64'h4000);
    chk("b_last", 64'(bif.last_addr_o), 64'h4000);
    chk("b_next", 64'(bif.next_addr_o), 64'h4002);
    tick;
    bif.ready_i = 1'b0;
    chk("drain_valid", 64'(bif.valid_o), 0);
    chk("drain_iaddr", 64'(bif.iaddr_o), 0);
    chk("drain_iret", 64'(bif.iretire_o), 0);
    chk("drain_itype", 64'(bif.itype_o), 0);
    chk("drain_last", 64'(bif.last_addr_o), 0);
    chk("drain_ret", 64'(bif.retired_hw_o), 6);

    // continuity after not-taken branch
    lane(0, 32'h2000, 16'd2, 1'b1, 3'd4);
    push;
    chk("seq_prev_none", 64'(bif.seq_err_o), 0);
    pop1;
    lane(0, 32'h2008, 16'd1, 1'b0, 3'd0);
    push;
    chk("seq_gap", 64'(bif.seq_err_o), 1);
    pop1;
    lane(0, 32'h2000, 16'd2, 1'b1, 3'd4);
    push;
    pop1;
    lane(0, 32'h2004, 16'd1, 1'b0, 3'd5);
    push;
    chk("seq_ok", 64'(bif.seq_err_o), 0);
    pop1;
    lane(0, 32'h9000, 16'd1, 1'b0, 3'd0);
    push;
    chk("seq_after_tbr", 64'(bif.seq_err_o), 0);
    pop1;
    chk("seq_ret", 64'(bif.retired_hw_o), 13);

    // trap-only block and address wrap
    lane(0, 32'h8000_0000, 16'd0, 1'b0, 3'd1);
    push;
    chk("trap_last", 64'(bif.last_addr_o), 64'h8000_0000);
    chk("trap_next", 64'(bif.next_addr_o), 64'h8000_0000);
    pop1;
    lane(0, 32'hFFFF_FFFC, 16'd4, 1'b1, 3'd0);
    push;
    chk("wrap_next", 64'(bif.next_addr_o), 64'h4);
    chk("wrap_last", 64'(bif.last_addr_o), 64'h0);
    pop1;
    lane(1, 32'h7000, 16'd1, 1'b0, 3'd0);
    push;
    chk("lane1_only", 64'(bif.iaddr_o), 64'h7000);
    chk("lane1_usage", 64'(bif.usage_o), 1);
    pop1;
    chk("wrap_ret", 64'(bif.retired_hw_o), 18);

    // fill and overflow
    lane(0, 32'h100, 16'd1, 1'b0, 3'd0); lane(1, 32'h104, 16'd1, 1'b0, 3'd0); push;
    lane(0, 32'h108, 16'd1, 1'b0, 3'd0); lane(1, 32'h10C, 16'd1, 1'b0, 3'd0); push;
    lane(0, 32'h110, 16'd1, 1'b0, 3'd0); lane(1, 32'h114, 16'd1, 1'b0, 3'd0); push;
    lane(1, 32'h118, 16'd1, 1'b0, 3'd0); push;
    chk("fill_usage", 64'(bif.usage_o), 7);
    chk("fill_ovf", 64'(bif.overflow_o), 0);
    lane(0, 32'hBAD0, 16'd1, 1'b0, 3'd0); lane(1, 32'hBAD4, 16'd1, 1'b0, 3'd0);
    bif.ready_i = 1'b1;
    push;
    bif.ready_i = 1'b0;
    chk("ovf_usage", 64'(bif.usage_o), 6);
    chk("ovf_flag", 64'(bif.overflow_o), 1);
    chk("ovf_drop", 64'(bif.drop_cnt_o), 2);
    chk("ovf_head", 64'(bif.iaddr_o), 64'h104);
    lane(0, 32'h11C, 16'd1, 1'b0, 3'd0); push;
    chk("ovf_accept1", 64'(bif.usage_o), 7);
    lane(0, 32'hBAD8, 16'd1, 1'b0, 3'd0); lane(1, 32'hBADC, 16'd1, 1'b0, 3'd0); push;
    chk("ovf2_drop", 64'(bif.drop_cnt_o), 4);
    chk("ovf2_usage", 64'(bif.usage_o), 7);
    lane(1, 32'h120, 16'd1, 1'b0, 3'd0); push;
    chk("full_usage", 64'(bif.usage_o), 8);
    lane(0, 32'hBAE0, 16'd1, 1'b0, 3'd0);
    bif.ready_i = 1'b1;
    push;
    bif.ready_i = 1'b0;
    chk("full_drop", 64'(bif.drop_cnt_o), 5);
    chk("full_usage2", 64'(bif.usage_o), 7);
    chk("full_head", 64'(bif.iaddr_o), 64'h108);
    pop1;
    chk("order_10c", 64'(bif.iaddr_o), 64'h10C);
    pop1;
    chk("order_110", 64'(bif.iaddr_o), 64'h110);
    chk("pre_rst_usage", 64'(bif.usage_o), 5);

    // asynchronous flush mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bif.valid_o), 0);
    chk("arst_usage", 64'(bif.usage_o), 0);
    chk("arst_ovf", 64'(bif.overflow_o), 0);
    chk("arst_drop", 64'(bif.drop_cnt_o), 0);
    chk("arst_ret", 64'(bif.retired_hw_o), 0);
    chk("arst_iaddr", 64'(bif.iaddr_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    lane(0, 32'h5000, 16'd1, 1'b0, 3'd0);
    chk("post_rst_idle", 64'(bif.valid_o), 0);
    push;
    chk("post_rst_valid", 64'(bif.valid_o), 1);
    chk("post_rst_head", 64'(bif.iaddr_o), 64'h5000);
    chk("post_rst_seq", 64'(bif.seq_err_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/te_block_reader.md
# te_block_reader

Receive side of the trace-block interface produced by the multiple-retirement stage. It accepts up to N encoder-ready blocks per cycle (iretire/ilastsize/itype/cause/tval/priv/iaddr), buffers them in order, and replays them one per cycle over a valid/ready handshake. While replaying, it reconstructs each block's last-instruction and next-sequential addresses and checks address continuity across not-taken branches. It sits between the retirement stage and a single-lane consumer, such as a reference model, scoreboard or serial encoder.

## Interface
- N, 1: input lanes per cycle; 1 ≤ N ≤ FIFO_DEPTH.
- FIFO_DEPTH, 16: block entries; power of two, ≥ 2.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  N  per-lane block valid; any lane pattern is legal.
- iretire_i  in  N×IRETIRE_LEN  halfwords retired by block.
- ilastsize_i  in  N  last instruction size: 1 = 32-bit, 0 = 16-bit.
- itype_i  in  N×ITYPE_LEN  block-ending instruction type.
- cause_i  in  N×CAUSE_LEN; tval_i  in  N×XLEN; priv_i  in  N×PRIV_LEN; iaddr_i  in  N×XLEN  block fields.
- valid_o  out  1  head block present.
- ready_i  in  1  consumer accepts head.
- iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o  out  single-lane widths  head block fields.
- last_addr_o  out  XLEN  address of the last retired instruction.
- next_addr_o  out  XLEN  sequential address after the block.
- seq_err_o  out  1  head breaks continuity.
- overflow_o  out  1  sticky: a group was dropped.
- drop_cnt_o  out  16  dropped-block count, saturating.
- retired_hw_o  out  32  total halfwords popped, wrapping.
- usage_o  out  $clog2(FIFO_DEPTH)+1  occupied entries.

## Operation
- Ingest: the lanes with valid_i set are compacted in lane order (lane 0 first) and written at consecutive write-pointer slots in the same edge.
- Admission: let k = popcount(valid_i) and free = FIFO_DEPTH − usage, using registered usage.
  - k ≤ free: all k blocks are written.
  - k > free: the whole group is dropped; no partial writes.
  - On a drop: overflow_o ← 1 (sticky until reset); drop_cnt_o += k, saturating at 0xFFFF.
- A pop in the same cycle does not create room for that cycle's push. A full FIFO rejects a group even when ready_i = 1.
- Replay: valid_o = (usage ≠ 0). The field outputs show the entry at the read pointer. When valid_o = 0, all data outputs are forced to 0.
- Pop on valid_o && ready_i: read pointer advances by one; retired_hw_o += iretire_o.
- usage next = usage + accepted k − pop.
- Pointers wrap modulo FIFO_DEPTH.
- Address arithmetic, all mod 2^XLEN:
  - next_addr_o = iaddr_o + (iretire_o << 1).
  - last_addr_o = next_addr_o − (ilastsize_o ? 4 : 2).
  - If iretire_o == 0 (trap-only block), last_addr_o = next_addr_o = iaddr_o.
- Continuity: on each pop, store prev_next ← next_addr_o, prev_itype ← itype_o, prev_v ← 1.
  - seq_err_o = valid_o && prev_v && prev_itype == ITYPE_NTBR (4) && iaddr_o ≠ prev_next.
  - Any other prev_itype never flags, since a discontinuity is legitimate there.
  - prev_v clears only at reset.
- seq_err_o is informational; it never stalls or drops a block.

## Timing
- Reset values:
  - valid_o, seq_err_o, overflow_o: 0.
  - All data outputs: 0.
  - drop_cnt_o, retired_hw_o, usage_o: 0.
  - Pointers and prev_v: 0.
- Latency: a block written at edge t appears on the outputs after edge t (earliest valid_o is the cycle after valid_i). There is no combinational input-to-output path.
- Throughput: 1 pop per cycle. Sustained ingest above 1 block per cycle fills the FIFO, then groups are dropped.
- valid_o holds and head data stays stable until ready_i is seen. ready_i may toggle freely.
- Address outputs and seq_err_o are combinational from the head entry and prev registers; they are valid in the same cycle as valid_o.
- Asserting reset mid-operation flushes everything asynchronously. There is no partial-pop state.

## Structure
- mure_pkg additions:
  - blk_entry_s: iretire, ilastsize, itype, cause, tval, priv, iaddr.
  - itype constants ITYPE_NONE=0, EXC=1, INT=2, ERET=3, NTBR=4, TBR=5.
- Storage is a register array of blk_entry_s, written through N write ports.
- Sub-module te_lane_compactor: prefix-sum lane compaction. It outputs the compacted entries and k.
- The address/continuity logic stays in the top module.

## Test plan
- Reset, N=2: push lane0 {iaddr=0x1000, iretire=3, ilastsize=1} -> next cycle valid_o=1, next_addr_o=0x1006, last_addr_o=0x1002; after pop, retired_hw_o=3.
- N=2, both lanes valid {A on lane0, B on lane1}, ready_i=0 for 3 cycles -> usage_o=2, head A stable; then ready_i=1 -> A then B on consecutive cycles, then valid_o=0 with data outputs 0.
- FIFO_DEPTH=4 with usage=3: push 2 lanes while ready_i=1 -> group dropped, overflow_o=1, drop_cnt_o=2, usage_o=2 next cycle; a later 1-lane push is accepted.
- Pop {itype=4, iaddr=0x2000, iretire=2} then present {iaddr=0x2008} -> seq_err_o=1; repeat with iaddr=0x2004 -> seq_err_o=0; previous itype=5 with any address -> 0.
- iretire=0, itype=1, iaddr=0x80000000 -> last_addr_o=next_addr_o=0x80000000; iaddr=0xFFFFFFFC (XLEN=32), iretire=4 -> next_addr_o=0x4 (wrap).
- Assert rst_ni low while usage=5 and overflow_o=1 -> all outputs 0 immediately; after release, the first push appears one cycle later.
